// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control strobes, program-ROM port, branch flags and fetch state outputs.
// Latency: none, signal bundle only.
// Backpressure: none; the control unit sequences fetch through the strobes.
interface fetch_unit_if #(
  parameter int PC_WIDTH = 16
);
  logic                IRload;
  logic                PCload;
  logic                JMPload;
  logic [7:0]          rom_data;
  logic                acc_zero;
  logic                carry;
  logic [PC_WIDTH-1:0] ret_addr;
  logic [PC_WIDTH-1:0] rom_addr;
  logic [PC_WIDTH-1:0] pc;
  logic [7:0]          Opcode;
  logic [7:0]          Operand;
  logic [PC_WIDTH-1:0] push_addr;
  logic                jmp_taken;
  logic [15:0]         jmp_count;

  // Fetch unit side
  modport slave (
    input  IRload, PCload, JMPload, rom_data, acc_zero, carry, ret_addr,
    output rom_addr, pc, Opcode, Operand, push_addr, jmp_taken, jmp_count
  );

  // Control unit / ROM side
  modport master (
    output IRload, PCload, JMPload, rom_data, acc_zero, carry, ret_addr,
    input  rom_addr, pc, Opcode, Operand, push_addr, jmp_taken, jmp_count
  );
endinterface

// File: rtl/fetch_unit.sv
// 8051 fetch stage: owns PC, latches opcode/operand, redirects PC for AJMP/ACALL/JZ/JNZ/JNC/RETI.
// Latency: one clock edge from strobe to pc/Opcode/Operand; jmp_taken follows the redirect edge.
// Backpressure: none; strobes are obeyed every cycle. FETCH_JMP_COUNT_EN adds the taken-jump counter.
module fetch_unit #(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic         clock,
  input  logic         reset,
  fetch_unit_if.slave  bus
);

  logic [PC_WIDTH-1:0] r_pc;
  logic [7:0]          r_opcode;
  logic [7:0]          r_operand;
  logic [PC_WIDTH-1:0] r_push_addr;
  logic                r_jmp_taken;
  logic                r_jmp_q;

  logic                w_jmp_edge;
  logic                w_is_ajmp;
  logic                w_is_acall;
  logic                w_is_reti;
  logic                w_rel_taken;
  logic                w_taken;
  logic [PC_WIDTH-1:0] w_abs_target;
  logic [PC_WIDTH-1:0] w_rel_target;
  logic [PC_WIDTH-1:0] w_target;

  // Only the first cycle of a JMPload window evaluates, so long windows redirect once.
  assign w_jmp_edge   = bus.JMPload & ~r_jmp_q;
  assign w_is_ajmp    = (r_opcode[4:0] == 5'h01);
  assign w_is_acall   = (r_opcode[4:0] == 5'h11);
  assign w_is_reti    = (r_opcode == 8'h32);
  // Relative base is the PC after the operand fetch, i.e. the next instruction.
  assign w_abs_target = {r_pc[PC_WIDTH-1:11], r_opcode[7:5], r_operand};
  assign w_rel_target = r_pc + {{(PC_WIDTH-8){r_operand[7]}}, r_operand};

  // Decode which redirect (if any) the current opcode requests and whether it is taken.
  always_comb begin
    w_rel_taken = 1'b0;
    w_target    = w_rel_target;
    case (r_opcode)
      8'h60:   w_rel_taken = bus.acc_zero;
      8'h70:   w_rel_taken = ~bus.acc_zero;
      8'h50:   w_rel_taken = ~bus.carry;
      default: w_rel_taken = 1'b0;
    endcase
    if (w_is_ajmp || w_is_acall) begin
      w_target = w_abs_target;
    end else if (w_is_reti) begin
      w_target = bus.ret_addr;
    end
  end

  assign w_taken = w_jmp_edge & (w_is_ajmp | w_is_acall | w_is_reti | w_rel_taken);

  // Program counter: a taken redirect beats the PCload increment.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (w_taken) begin
      r_pc <= w_target;
    end else if (bus.PCload) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  // Instruction and operand byte latches from the zero-latency ROM.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_opcode  <= 8'h00;
      r_operand <= 8'h00;
    end else begin
      if (bus.IRload) begin
        r_opcode <= bus.rom_data;
      end
      if (bus.PCload && !bus.IRload) begin
        r_operand <= bus.rom_data;
      end
    end
  end

  // Jump window edge tracking, ACALL return address capture and taken pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_jmp_q     <= 1'b0;
      r_push_addr <= '0;
      r_jmp_taken <= 1'b0;
    end else begin
      r_jmp_q     <= bus.JMPload;
      r_jmp_taken <= w_taken;
      if (w_jmp_edge && w_is_acall) begin
        r_push_addr <= r_pc;
      end
    end
  end

`ifdef FETCH_JMP_COUNT_EN
  logic [15:0] r_jmp_count;

  // Saturating count of taken-jump pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_jmp_count <= 16'h0000;
    end else if (r_jmp_taken && (r_jmp_count != 16'hFFFF)) begin
      r_jmp_count <= r_jmp_count + 16'h0001;
    end
  end

  assign bus.jmp_count = r_jmp_count;
`else
  assign bus.jmp_count = 16'h0000;
`endif

  assign bus.rom_addr  = r_pc;
  assign bus.pc        = r_pc;
  assign bus.Opcode    = r_opcode;
  assign bus.Operand   = r_operand;
  assign bus.push_addr = r_push_addr;
  assign bus.jmp_taken = r_jmp_taken;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against a cycle-level reference model.
module tb_fetch_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fetch_unit_if #(.PC_WIDTH(16)) bus ();
  fetch_unit #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] rom [256];
  assign bus.rom_data = rom[bus.rom_addr[7:0]];

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [15:0] m_pc, m_push, m_cnt;
  logic [7:0]  m_op, m_opd;
  logic        m_jt, m_jq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Next state from the rules: reset, fetch strobes, edge-detected jump decode.
  task automatic model_step();
    logic        edge_now, taken, is_abs;
    logic [15:0] tgt, rel;
    logic [7:0]  rd;
    rd  = rom[m_pc[7:0]];
    if (reset) begin
      m_pc = 16'h0; m_op = 8'h0; m_opd = 8'h0; m_push = 16'h0;
      m_jt = 1'b0; m_jq = 1'b0; m_cnt = 16'h0;
      return;
    end
    edge_now = bus.JMPload && !m_jq;
    is_abs   = (m_op[4:0] == 5'h01) || (m_op[4:0] == 5'h11);
    rel      = m_pc + 16'(signed'(m_opd));
    taken    = 1'b0;
    tgt      = m_pc;
    if (edge_now) begin
      if (is_abs) begin
        taken = 1'b1;
        tgt   = (m_pc & 16'hF800) | (16'(m_op[7:5]) << 8) | 16'(m_opd);
      end else if (m_op == 8'h32) begin
        taken = 1'b1;
        tgt   = bus.ret_addr;
      end else if (m_op == 8'h60 && bus.acc_zero)  begin taken = 1'b1; tgt = rel; end
      else if (m_op == 8'h70 && !bus.acc_zero)     begin taken = 1'b1; tgt = rel; end
      else if (m_op == 8'h50 && !bus.carry)        begin taken = 1'b1; tgt = rel; end
    end
`ifdef FETCH_JMP_COUNT_EN
    if (m_jt && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
    if (edge_now && m_op[4:0] == 5'h11) m_push = m_pc;
    if (bus.PCload && !bus.IRload) m_opd = rd;
    if (bus.IRload) m_op = rd;
    if (taken) m_pc = tgt;
    else if (bus.PCload) m_pc = m_pc + 16'd1;
    m_jq = bus.JMPload;
    m_jt = taken;
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},        32'(bus.pc),        32'(m_pc));
    check({tag, ".rom_addr"},  32'(bus.rom_addr),  32'(m_pc));
    check({tag, ".Opcode"},    32'(bus.Opcode),    32'(m_op));
    check({tag, ".Operand"},   32'(bus.Operand),   32'(m_opd));
    check({tag, ".push_addr"}, 32'(bus.push_addr), 32'(m_push));
    check({tag, ".jmp_taken"}, 32'(bus.jmp_taken), 32'(m_jt));
    check({tag, ".jmp_count"}, 32'(bus.jmp_count), 32'(m_cnt));
  endtask

  // Place pc=tpc, Opcode=op, Operand=opd using RETI, an operand fetch and an opcode-only load.
  task automatic setup(input logic [15:0] tpc, input logic [7:0] op, input logic [7:0] opd);
    logic [15:0] tm1;
    tm1 = tpc - 16'd1;
    rom[m_pc[7:0]] = 8'h32; bus.IRload = 1'b1; tick(); bus.IRload = 1'b0;
    bus.ret_addr = tm1; bus.JMPload = 1'b1; tick(); bus.JMPload = 1'b0;
    rom[tm1[7:0]] = opd; bus.PCload = 1'b1; tick(); bus.PCload = 1'b0;
    rom[tpc[7:0]] = op; bus.IRload = 1'b1; tick(); bus.IRload = 1'b0;
    tick();
  endtask

  task automatic jmp_pulse();
    bus.JMPload = 1'b1; tick(); bus.JMPload = 1'b0;
  endtask

  int pulses;
  logic [7:0] pick [10];

  initial begin
    bus.IRload = 0; bus.PCload = 0; bus.JMPload = 0;
    bus.acc_zero = 0; bus.carry = 0; bus.ret_addr = 16'h0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    m_pc = 16'h0; m_op = 8'h0; m_opd = 8'h0; m_push = 16'h0;
    m_jt = 0; m_jq = 0; m_cnt = 16'h0;

    // Reset state
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    check("rst.pc", 32'(bus.pc), 32'h0);
    check("rst.Opcode", 32'(bus.Opcode), 32'h0);
    check("rst.Operand", 32'(bus.Operand), 32'h0);
    check("rst.push_addr", 32'(bus.push_addr), 32'h0);
    check("rst.jmp_taken", 32'(bus.jmp_taken), 32'h0);
    check("rst.jmp_count", 32'(bus.jmp_count), 32'h0);

    // Linear fetch: fetch1, wait, fetch2
    rom[0] = 8'h74; rom[1] = 8'h55;
    bus.IRload = 1; bus.PCload = 1; tick(); bus.IRload = 0; bus.PCload = 0;
    tick();
    bus.PCload = 1; tick(); bus.PCload = 0;
    check("lin.Opcode", 32'(bus.Opcode), 32'h74);
    check("lin.Operand", 32'(bus.Operand), 32'h55);
    check("lin.pc", 32'(bus.pc), 32'h2);

    // Reset mid-sequence
    setup(16'h0123, 8'hE8, 8'h00);
    check("pre_rst.pc", 32'(bus.pc), 32'h0123);
    check("pre_rst.Opcode", 32'(bus.Opcode), 32'hE8);
    reset = 1'b1; tick(); reset = 1'b0;
    check("mid_rst.pc", 32'(bus.pc), 32'h0);
    check("mid_rst.Opcode", 32'(bus.Opcode), 32'h0);
    check("mid_rst.Operand", 32'(bus.Operand), 32'h0);
    check("mid_rst.jmp_taken", 32'(bus.jmp_taken), 32'h0);

    // AJMP with a two-cycle JMPload window
    setup(16'h1802, 8'hA1, 8'h34);
    pulses = 0;
    bus.JMPload = 1; tick(); pulses += int'(bus.jmp_taken);
    check("ajmp.pc1", 32'(bus.pc), 32'h1D34);
    tick(); pulses += int'(bus.jmp_taken);
    check("ajmp.pc2", 32'(bus.pc), 32'h1D34);
    bus.JMPload = 0; tick(); pulses += int'(bus.jmp_taken);
    check("ajmp.pulses", 32'(pulses), 32'd1);

    // JZ taken and not taken
    setup(16'h0010, 8'h60, 8'hFE);
    bus.acc_zero = 1; jmp_pulse();
    check("jz_t.pc", 32'(bus.pc), 32'h000E);
    check("jz_t.jmp_taken", 32'(bus.jmp_taken), 32'h1);
    setup(16'h0010, 8'h60, 8'hFE);
    bus.acc_zero = 0; jmp_pulse();
    check("jz_n.pc", 32'(bus.pc), 32'h0010);
    check("jz_n.jmp_taken", 32'(bus.jmp_taken), 32'h0);

    // ACALL then RETI
    setup(16'h0202, 8'h11, 8'h80);
    jmp_pulse();
    check("acall.push_addr", 32'(bus.push_addr), 32'h0202);
    check("acall.pc", 32'(bus.pc), 32'h0080);
    tick();
    rom[8'h80] = 8'h32; bus.IRload = 1; tick(); bus.IRload = 0;
    bus.ret_addr = 16'h0202; jmp_pulse();
    check("reti.pc", 32'(bus.pc), 32'h0202);

    // Jump counter: 3 taken, then JNC not taken with carry=1
    reset = 1'b1; tick(); reset = 1'b0;
    rom[0] = 8'h32; bus.IRload = 1; tick(); bus.IRload = 0;
    bus.ret_addr = 16'h0040;
    jmp_pulse(); tick(); jmp_pulse(); tick(); jmp_pulse(); tick();
    rom[8'h40] = 8'h50; bus.IRload = 1; tick(); bus.IRload = 0;
    bus.carry = 1; jmp_pulse();
    check("jnc_n.pc", 32'(bus.pc), 32'h0040);
    check("jnc_n.jmp_taken", 32'(bus.jmp_taken), 32'h0);
    tick(); tick();
`ifdef FETCH_JMP_COUNT_EN
    check("cnt.jmp_count", 32'(bus.jmp_count), 32'd3);
`else
    check("cnt.jmp_count", 32'(bus.jmp_count), 32'd0);
`endif

    // Randomized run against the model, including jump+PCload collisions
    pick = '{8'h01, 8'h21, 8'hE1, 8'h11, 8'hB1, 8'h60, 8'h70, 8'h50, 8'h32, 8'hE8};
    for (int i = 0; i < 256; i++)
      rom[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pick[$urandom_range(0, 9)];
    for (int c = 0; c < 600; c++) begin
      reset        = ($urandom_range(0, 99) == 0);
      bus.IRload   = ($urandom_range(0, 2) == 0);
      bus.PCload   = ($urandom_range(0, 1) == 0);
      bus.JMPload  = ($urandom_range(0, 2) == 0);
      bus.acc_zero = 1'($urandom);
      bus.carry    = 1'($urandom);
      bus.ret_addr = 16'($urandom);
      tick();
      check_all("rnd");
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
